// File: rtl/sipo_deser.sv
// Serial-in / parallel-out deserializer.
// Assembles WIDTH serial bits (MSB- or LSB-first, direction latched on the first bit)
// into a word presented with a valid/ready handshake. A word that completes while
// the previous one is still unconsumed is dropped and flagged through a sticky overrun.
module sipo_deser #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  input  logic                     frame_start,
  input  logic                     msb_first,
  output logic [WIDTH-1:0]         data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun,
  input  logic                     clr_ovr
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              dir_q, dir_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  logic              restart;
  logic [CntW-1:0]   pos;
  logic              dir;
  logic [WIDTH-1:0]  base;
  logic [WIDTH-1:0]  word;
  logic              last;
  logic              xfer;
  logic              lost;

  // Bit insertion: a new word starts from a clean register at position 0, either from
  // IDLE or when frame_start aborts the partial word in the same cycle.
  always_comb begin
    restart = frame_start || (state_q == StIdle);
    pos     = restart ? '0 : cnt_q;
    dir     = restart ? msb_first : dir_q;
    base    = restart ? '0 : shreg_q;
    word    = base;
    if (dir) begin
      word = {base[WIDTH-2:0], ser_in};
    end else begin
      word[pos] = ser_in;
    end
    last = ser_valid && (pos == CntW'(WIDTH - 1));
    xfer = valid_q && out_ready;
    lost = last && valid_q && !out_ready;
  end

  // Next-state for the accumulator FSM and the output handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dir_d   = dir_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (frame_start) begin
      state_d = StIdle;
      cnt_d   = '0;
      shreg_d = '0;
    end

    if (ser_valid) begin
      dir_d = dir;
      if (last) begin
        state_d = StIdle;
        cnt_d   = '0;
        shreg_d = '0;
      end else begin
        state_d = StAccum;
        cnt_d   = pos + CntW'(1);
        shreg_d = word;
      end
    end

    // A completing word may replace one being consumed this cycle; otherwise it is lost.
    if (last && !lost) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    // Set has priority over clear.
    if (lost) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  // State and registered outputs; direction defaults to MSB-first out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      dir_q   <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign bit_cnt   = cnt_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Testbench for sipo_deser: table-driven words, directed corner sequences and a
// randomized phase checked against a bit-queue reference model.
module tb_sipo_deser;

  localparam int unsigned W = 16;

  logic          clk;
  logic          rst_n;
  logic          ser_in;
  logic          ser_valid;
  logic          frame_start;
  logic          msb_first;
  logic [W-1:0]  data_out;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    bit_cnt;
  logic          overrun;
  logic          clr_ovr;

  int checks;
  int errors;

  // Reference model state: bits of the partial word in arrival order.
  logic          mq[$];
  logic          mdir;
  logic [W-1:0]  mdata;
  logic          mvalid;
  logic          movr;

  typedef struct {
    logic          msb;
    logic [W-1:0]  stream;  // stream[W-1] is sent first
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vecs[6];

  sipo_deser #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ser_in      (ser_in),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .msb_first   (msb_first),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .bit_cnt     (bit_cnt),
    .overrun     (overrun),
    .clr_ovr     (clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mdir   = 1'b1;
    mdata  = '0;
    mvalid = 1'b0;
    movr   = 1'b0;
  endtask

  // One clock of the model, computed from the current inputs.
  task automatic model_step();
    logic [W-1:0] w;
    logic         done;
    logic         lost;
    done = 1'b0;
    w    = '0;
    if (frame_start) mq.delete();
    if (ser_valid) begin
      if (mq.size() == 0) mdir = msb_first;
      mq.push_back(ser_in);
    end
    if (mq.size() == W) begin
      for (int i = 0; i < W; i++) begin
        if (mdir) w[W-1-i] = mq[i];
        else      w[i]     = mq[i];
      end
      mq.delete();
      done = 1'b1;
    end
    lost = done && mvalid && !out_ready;
    if (done && !lost) begin
      mdata  = w;
      mvalid = 1'b1;
    end else if (mvalid && out_ready) begin
      mvalid = 1'b0;
    end
    if (lost)         movr = 1'b1;
    else if (clr_ovr) movr = 1'b0;
  endtask

  task automatic tick();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("model data_out", 32'(data_out), 32'(mdata));
    chk("model out_valid", 32'(out_valid), 32'(mvalid));
    chk("model overrun", 32'(overrun), 32'(movr));
    chk("model bit_cnt", 32'(bit_cnt), mq.size());
  endtask

  task automatic send_bit(input logic b);
    ser_valid = 1'b1;
    ser_in    = b;
    tick();
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  // Sends the first n bits of stream, most significant first.
  task automatic send_bits(input logic [W-1:0] stream, input int n);
    for (int i = 0; i < n; i++) send_bit(stream[W-1-i]);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    ser_in      = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    msb_first   = 1'b1;
    out_ready   = 1'b1;
    clr_ovr     = 1'b0;
    model_reset();

    vecs[0] = '{msb: 1'b1, stream: 16'b1010_0101_1100_0011, exp: 16'hA5C3};
    vecs[1] = '{msb: 1'b0, stream: 16'b1010_0101_1100_0011, exp: 16'hC3A5};
    vecs[2] = '{msb: 1'b1, stream: 16'h1234, exp: 16'h1234};
    vecs[3] = '{msb: 1'b0, stream: 16'h0001, exp: 16'h8000};
    vecs[4] = '{msb: 1'b0, stream: 16'hF000, exp: 16'h000F};
    vecs[5] = '{msb: 1'b1, stream: 16'h00FF, exp: 16'h00FF};

    // Reset state, and no change on an edge while reset is held.
    #1;
    ser_valid = 1'b1;
    ser_in    = 1'b1;
    tick();
    chk("reset bit_cnt", 32'(bit_cnt), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset data_out", 32'(data_out), 0);
    chk("reset overrun", 32'(overrun), 0);
    ser_valid = 1'b0;
    ser_in    = 1'b0;
    rst_n     = 1'b1;
    tick();

    // Table-driven words with the consumer always ready.
    for (int v = 0; v < 6; v++) begin
      msb_first = vecs[v].msb;
      send_bits(vecs[v].stream, W - 1);
      chk("vec bit_cnt before last", 32'(bit_cnt), W - 1);
      chk("vec no early valid", 32'(out_valid), 0);
      msb_first = ~vecs[v].msb;  // must be ignored mid-word
      send_bit(vecs[v].stream[0]);
      chk("vec data_out", 32'(data_out), 32'(vecs[v].exp));
      chk("vec out_valid", 32'(out_valid), 1);
      chk("vec bit_cnt", 32'(bit_cnt), 0);
      tick();
      chk("vec consumed", 32'(out_valid), 0);
      check_model();
    end

    // Overrun: held word survives a second completion; clr_ovr clears the flag.
    msb_first = 1'b1;
    out_ready = 1'b0;
    send_bits(16'h1234, W);
    chk("hold data_out", 32'(data_out), 32'h1234);
    chk("hold out_valid", 32'(out_valid), 1);
    send_bits(16'hFFFF, W);
    chk("ovr data_out", 32'(data_out), 32'h1234);
    chk("ovr overrun", 32'(overrun), 1);
    chk("ovr out_valid", 32'(out_valid), 1);
    tick();
    chk("ovr sticky", 32'(overrun), 1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("clr overrun", 32'(overrun), 0);
    chk("clr keeps valid", 32'(out_valid), 1);

    // Ready rises exactly when the next word completes: replace, no overrun.
    send_bits(16'hBEEF, W - 1);
    out_ready = 1'b1;
    send_bit(1'b1);
    chk("swap data_out", 32'(data_out), 32'hBEEF);
    chk("swap out_valid", 32'(out_valid), 1);
    chk("swap overrun", 32'(overrun), 0);
    tick();
    check_model();

    // frame_start with a bit in the same cycle starts a fresh word.
    send_bits(16'hFFFF, 7);
    chk("abort bit_cnt before", 32'(bit_cnt), 7);
    frame_start = 1'b1;
    send_bit(1'b1);
    frame_start = 1'b0;
    chk("abort bit_cnt after", 32'(bit_cnt), 1);
    send_bits(16'h0003, W - 1);  // remaining 15 bits of 8001: 000_0000_0000_0001
    chk("abort data_out", 32'(data_out), 32'h8001);
    chk("abort bit_cnt", 32'(bit_cnt), 0);
    chk("abort out_valid", 32'(out_valid), 1);
    check_model();

    // Asynchronous reset mid-word, then a clean word.
    out_ready = 1'b0;
    send_bits(16'hAAAA, 9);
    chk("pre-reset bit_cnt", 32'(bit_cnt), 9);
    rst_n = 1'b0;
    #1;
    chk("async data_out", 32'(data_out), 0);
    chk("async out_valid", 32'(out_valid), 0);
    chk("async bit_cnt", 32'(bit_cnt), 0);
    chk("async overrun", 32'(overrun), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    msb_first = 1'b1;
    send_bits(16'h00FF, W);
    chk("post-reset data_out", 32'(data_out), 32'h00FF);
    chk("post-reset out_valid", 32'(out_valid), 1);
    check_model();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      ser_valid   = ($urandom_range(3) != 0);
      ser_in      = $urandom_range(1);
      msb_first   = $urandom_range(1);
      frame_start = ($urandom_range(31) == 0);
      out_ready   = ($urandom_range(2) == 0);
      clr_ovr     = ($urandom_range(15) == 0);
      tick();
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
